// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, baud
// defaults and the frame-length helper.
package uart_tx_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned BAUD       = 115200;
  localparam int unsigned BAUD_DIV   = CLK_HZ / BAUD;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

  // Clock cycles one frame occupies, including the idle guard tail.
  function automatic int unsigned frame_cycles(input int unsigned bits,
                                               input int unsigned div,
                                               input int unsigned guard);
    return bits * div + guard;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational requester picker. Default: round-robin, scanning from the
// slot after ptr. With UART_TX_ARB_PRIO_EN defined: fixed priority, lowest
// index wins and ptr is ignored.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    index
);

`ifdef UART_TX_ARB_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest set bit wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IW'(i);
      end
    end
  end
`else
  // First set bit at ptr+1, ptr+2, ... wins; scanning the offsets in reverse
  // lets the nearest one overwrite the rest.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      if (req[IW'((int'(ptr) + k) % int'(N_REQ))]) begin
        valid = 1'b1;
        index = IW'((int'(ptr) + k) % int'(N_REQ));
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers. One byte per
// grant; the block times each frame (plus guard) itself because the
// transmitter has no done/busy indication.
// Build option: UART_TX_ARB_PRIO_EN selects fixed priority instead of
// round-robin.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BAUD_DIV   = uart_tx_pkg::BAUD_DIV,
  parameter int unsigned FRAME_BITS = uart_tx_pkg::FRAME_BITS,
  parameter int unsigned GUARD      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   last_id
);

  import uart_tx_pkg::*;

  localparam int unsigned IW           = $clog2(N_REQ);
  localparam int unsigned FRAME_CYCLES = frame_cycles(FRAME_BITS, BAUD_DIV, GUARD);
  localparam int unsigned CW           = $clog2(FRAME_CYCLES + 1);

  state_e              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_n;
  logic [IW-1:0]       win_q, win_n;
  logic [N_REQ-1:0]    gnt_n;
  logic                tx_start_n;
  logic [DATA_W-1:0]   tx_data_n;
  logic                busy_n;
  logic [IW-1:0]       last_id_n;

  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic [DATA_W-1:0]   pick_data;
  logic [N_REQ-1:0]    win_onehot;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Byte of the current pick, muxed with constant slice bases.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_idx == IW'(i)) pick_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // One-hot form of the latched winner for the grant pulse.
  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      win_onehot[i] = (win_q == IW'(i));
    end
  end

  // State and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= IW'(N_REQ - 1);
      win_q    <= '0;
      gnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      last_id  <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      rr_ptr_q <= rr_ptr_n;
      win_q    <= win_n;
      gnt      <= gnt_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      busy     <= busy_n;
      last_id  <= last_id_n;
    end
  end

  // Next state: pick in IDLE, pulse in LOAD, count the frame out in SEND.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    rr_ptr_n   = rr_ptr_q;
    win_n      = win_q;
    gnt_n      = '0;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;
    busy_n     = busy;
    last_id_n  = last_id;
    case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (pick_valid) begin
          state_n   = LOAD;
          win_n     = pick_idx;
          tx_data_n = pick_data;
`ifndef UART_TX_ARB_PRIO_EN
          rr_ptr_n  = pick_idx;
`endif
        end
      end
      LOAD: begin
        gnt_n      = win_onehot;
        tx_start_n = 1'b1;
        busy_n     = 1'b1;
        last_id_n  = win_q;
        cnt_n      = CW'(FRAME_CYCLES - 1);
        state_n    = SEND;
      end
      SEND: begin
        busy_n = 1'b1;
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with BAUD_DIV=4, GUARD=2 (42-cycle frames).
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int FC = 10 * 4 + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   slot [N];
  logic [N-1:0]    gnt;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            busy;
  logic [1:0]      last_id;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = slot[i];
  end

  uart_tx_arbiter #(
    .N_REQ      (N),
    .DATA_W     (DW),
    .BAUD_DIV   (4),
    .FRAME_BITS (10),
    .GUARD      (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .last_id  (last_id)
  );

  typedef struct {
    logic [3:0]      req;
    logic [4:0][1:0] order;
  } vec_t;

  vec_t vecs [6];

  int          vectors    = 0;
  int          miscompares = 0;
  int          n     = 0;
  int          m_free = 0;
  int          m_rr  = N - 1;
  int          m_sel = -1000;
  int          m_w   = 0;
  int          m_last = 0;
  logic [7:0]  m_txd = 8'h00;
  logic [3:0]  gnt_seen;

  function automatic vec_t mk(input logic [3:0] r, input int o0, input int o1,
                              input int o2, input int o3, input int o4);
    vec_t v;
    v.req      = r;
    v.order[0] = 2'(o0);
    v.order[1] = 2'(o1);
    v.order[2] = 2'(o2);
    v.order[3] = 2'(o3);
    v.order[4] = 2'(o4);
    return v;
  endfunction

  // Reference choice of winner given the sampled requests and the last winner.
  function automatic int pick(input logic [3:0] r, input int last);
`ifdef UART_TX_ARB_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[2'((last + k) % N)]) return (last + k) % N;
`endif
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at edge %0d: no grant seen within the cycle budget", name, n);
  endtask

  // One clock: advance the reference on the edge, compare on the falling edge.
  task automatic cycle();
    int w;
    @(posedge clk);
    n++;
    if (reset) begin
      m_free = n + 1;
      m_rr   = N - 1;
      m_txd  = 8'h00;
      m_last = 0;
      m_sel  = -1000;
    end else if (n >= m_free && req != 4'b0000) begin
      w      = pick(req, m_rr);
      m_sel  = n;
      m_w    = w;
      m_txd  = slot[w];
      m_free = n + FC + 2;
`ifndef UART_TX_ARB_PRIO_EN
      m_rr   = w;
`endif
    end
    @(negedge clk);
    if (n == m_sel + 1) m_last = m_w;
    chk("gnt",      int'(gnt),      (n == m_sel + 1) ? (1 << m_w) : 0);
    chk("tx_start", int'(tx_start), (n == m_sel + 1) ? 1 : 0);
    chk("tx_data",  int'(tx_data),  int'(m_txd));
    chk("busy",     int'(busy),     (n >= m_sel + 1 && n <= m_sel + FC + 1) ? 1 : 0);
    chk("last_id",  int'(last_id),  m_last);
    gnt_seen |= gnt;
  endtask

  task automatic wait_gnt(input string name, output int id, output int lat);
    id  = -1;
    lat = 0;
    while (id < 0 && lat < 200) begin
      cycle();
      lat++;
      for (int i = 0; i < N; i++) if (gnt[i]) id = i;
    end
    if (id < 0) timeout_fail(name);
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int id, lat, prev, bc, exp_id;
    reset    = 1'b1;
    req      = '0;
    gnt_seen = '0;
    for (int i = 0; i < N; i++) slot[i] = 8'h00;

`ifdef UART_TX_ARB_PRIO_EN
    vecs[0] = mk(4'b0001, 0, 0, 0, 0, 0);
    vecs[1] = mk(4'b1111, 0, 0, 0, 0, 0);
    vecs[2] = mk(4'b1010, 1, 1, 1, 1, 1);
    vecs[3] = mk(4'b0110, 1, 1, 1, 1, 1);
    vecs[4] = mk(4'b1001, 0, 0, 0, 0, 0);
    vecs[5] = mk(4'b0011, 0, 0, 0, 0, 0);
`else
    vecs[0] = mk(4'b0001, 0, 0, 0, 0, 0);
    vecs[1] = mk(4'b1111, 0, 1, 2, 3, 0);
    vecs[2] = mk(4'b1010, 1, 3, 1, 3, 1);
    vecs[3] = mk(4'b0110, 1, 2, 1, 2, 1);
    vecs[4] = mk(4'b1001, 0, 3, 0, 3, 0);
    vecs[5] = mk(4'b0011, 0, 1, 0, 1, 0);
`endif

    // Reset state.
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_gnt",  int'(gnt),  0);

    // Single request: two-cycle latency, 43 busy cycles, byte and id.
    slot[2] = 8'hA5;
    req     = 4'b0100;
    wait_gnt("single", id, lat);
    req = '0;
    chk("single_id",   id,            2);
    chk("single_lat",  lat,           2);
    chk("single_data", int'(tx_data), 'hA5);
    chk("single_last", int'(last_id), 2);
    bc = 1;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (!busy) break;
      bc++;
    end
    chk("busy_len", bc, FC + 1);

    // Held request patterns: grant order, bytes and pulse spacing.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) slot[i] = 8'(8'h10 + i);
      req  = vecs[v].req;
      prev = 0;
      for (int g = 0; g < 5; g++) begin
        wait_gnt("table", id, lat);
        chk("order", id, int'(vecs[v].order[g]));
        chk("order_data", int'(tx_data), 'h10 + int'(vecs[v].order[g]));
        if (g > 0) chk("spacing", n - prev, FC + 2);
        prev = n;
      end
      req = '0;
    end

    // req[1] held, req[3] raised mid-frame.
    do_reset();
    req = 4'b0010;
    wait_gnt("mid_a", id, lat);
    chk("mid_first", id, 1);
    repeat (10) cycle();
    req[3] = 1'b1;
    wait_gnt("mid_b", id, lat);
`ifdef UART_TX_ARB_PRIO_EN
    exp_id = 1;
`else
    exp_id = 3;
`endif
    chk("mid_second", id, exp_id);
    req[3] = 1'b0;
    wait_gnt("mid_c", id, lat);
    chk("mid_third", id, 1);
    req = '0;
    repeat (FC + 4) cycle();

    // Withdrawn request never granted.
    do_reset();
    gnt_seen = '0;
    req = 4'b0100;
    wait_gnt("wd", id, lat);
    req = '0;
    repeat (5) cycle();
    req[0] = 1'b1;
    repeat (10) cycle();
    req[0] = 1'b0;
    repeat (FC + 10) cycle();
    chk("withdraw_gnt0", int'(gnt_seen[0]), 0);

    // Reset mid-SEND, then a pending req[3] gets the normal latency.
    do_reset();
    req = 4'b0100;
    wait_gnt("rst_a", id, lat);
    req = '0;
    repeat (19) cycle();
    req[3] = 1'b1;
    reset  = 1'b1;
    cycle();
    chk("rst_busy",  int'(busy),     0);
    chk("rst_start", int'(tx_start), 0);
    reset = 1'b0;
    wait_gnt("rst_b", id, lat);
    chk("rst_id",  id,  3);
    chk("rst_lat", lat, 2);
    req = '0;

    // Randomised producers against the reference.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(7) == 0) begin
            slot[i] = 8'($urandom);
            req[i]  = 1'b1;
          end
        end else if ($urandom_range(63) == 0 && !(m_sel == n && m_w == i)) begin
          req[i] = 1'b0;
        end
      end
      reset = ($urandom_range(499) == 0);
    end
    reset = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
